wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the shared 18-bit register-file write port among six writeback sources: ALU, load data, PC link, immediate, I/O in and shift unit.
- Produces the 3-bit select for the 6:1 18-bit writeback mux, plus the write enable and destination address.
- Grants are registered, so select, enable and address are all valid in the same cycle as the one-hot grant.
- Sits between the execute/memory stages and the register file.

Parameters:
- AW, 4, destination register address width.
- RR_EN, 1, 1 selects round-robin arbitration; 0 selects fixed priority with index 0 highest.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  6  per-source write request; level signal.
- dst  in  6*AW  per-source destination address; source i occupies dst[i*AW +: AW].
- hold  in  1  pipeline stall; blocks new grants.
- gnt  out  6  one-hot grant, registered; all-zero when idle.
- sel  out  3  writeback mux select, registered.
- we  out  1  register-file write enable, registered; equals |gnt.
- waddr  out  AW  register-file write address, registered.
- busy  out  1  high when any masked request is pending but not granted this cycle.

Behaviour:
- Reset:
  - gnt=0, sel=3'b000, we=0, waddr=0, busy=0.
  - Round-robin pointer ptr=0.
  - Reset dominates hold and req.
  - Reset asserted mid-grant clears all outputs on the next edge. The interrupted write is dropped; the requester re-requests.
- Select encoding, source index to sel:
  - 0→000, 1→001, 2→010, 3→100, 4→101, 5→110.
  - Codes 011 and 111 are never driven.
- Request masking:
  - Each edge arbitrates over eff = req & ~gnt, where gnt is the current registered value.
  - A granted source therefore cannot be granted in two consecutive cycles.
  - A source must drop req by the end of its grant cycle. If req is still high in the following cycle, it is a new request.
- Arbitration at each edge when rst=0 and hold=0:
  - RR_EN=1: scan eff starting at index ptr, ascending, wrapping 5→0. The first set bit i wins.
  - RR_EN=0: the lowest set index in eff wins.
- Register updates on a win:
  - gnt ← one-hot(i); sel ← enc(i); waddr ← dst[i]; we ← 1.
  - RR_EN=1 only: ptr ← (i==5) ? 0 : i+1.
- No win (eff=0):
  - gnt ← 0, we ← 0.
  - sel and waddr hold their last values.
  - ptr unchanged.
- hold=1:
  - gnt ← 0, we ← 0; sel, waddr and ptr frozen.
  - Pending requests are retained by the requesters (req is level).
  - Grants resume on the first edge with hold=0.
- Latency: a request seen at edge N is granted at edge N+1 at the earliest, i.e. one cycle from request to write.
- Throughput: one write per cycle when two or more sources request.
- Fairness (RR_EN=1): a continuously requesting source waits at most 5 grants.
- busy is registered from the same edge: busy ← (eff & ~one-hot(winner)) != 0. Under hold=1, busy ← (req != 0).
- Simultaneous events:
  - Requests from all six sources in the same cycle are resolved purely by the pointer or priority; there is no error.
  - Sources granted in consecutive cycles may target the same waddr; there is no hazard check. Ordering is the grant order.
- dst is sampled only at the winning edge; changes to dst on non-winning cycles are ignored.

Test Plan:
1. Reset:
   - Hold rst=1 for 3 cycles with req=6'h3F.
   - Required: gnt=0, we=0, sel=000, waddr=0, busy=0 throughout.
   - First grant after release goes to source 0.
2. Single request:
   - req=6'b000100, dst[2]=5 for one cycle.
   - Required next cycle: gnt=000100, sel=010, we=1, waddr=5.
   - Cycle after that: we=0, gnt=0, sel stays 010.
3. Round-robin sweep (RR_EN=1):
   - req=6'h3F held constantly.
   - Required: grants cycle 0,1,2,3,4,5,0 on consecutive cycles; sel=000,001,010,100,101,110,000; busy=1 throughout.
4. Stall:
   - req=6'b001001 with hold=1 for 4 cycles.
   - Required: we=0 and busy=1 during the stall.
   - On release: source 0 is granted, then source 3 on the next cycle.
5. Fixed priority (RR_EN=0):
   - req[1] and req[5] held constantly.
   - Required: source 1 is granted every other cycle because of masking, source 5 in between; no source is granted on two consecutive cycles.
6. Reset mid-stream:
   - Assert rst during a grant to source 4.
   - Required: next cycle all outputs are zero.
   - After release with req=6'h30: source 4 is granted first (ptr reset to 0, scan reaches 4), then source 5.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback port arbiter bus bundle.
// Requesters drive req/dst/hold; the arbiter returns grant, mux select and write port.
interface wb_port_arbiter_if #(
    parameter int AW = 4
);
    logic [5:0]      req;
    logic [6*AW-1:0] dst;
    logic            hold;
    logic [5:0]      gnt;
    logic [2:0]      sel;
    logic            we;
    logic [AW-1:0]   waddr;
    logic            busy;

    modport master (
        output req, dst, hold,
        input  gnt, sel, we, waddr, busy
    );

    modport slave (
        input  req, dst, hold,
        output gnt, sel, we, waddr, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Six-source register-file write port arbiter.
// Registered one-hot grant with matching mux select, write enable and address.
module wb_port_arbiter #(
    parameter int AW    = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    wb_port_arbiter_if.slave    bus
);

    logic [5:0]    r_gnt;
    logic [2:0]    r_sel;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic          r_busy;
    logic [2:0]    r_ptr;

    logic [5:0]    w_eff;
    logic [2:0]    w_start;
    logic          w_found;
    logic [2:0]    w_idx;
    logic [5:0]    w_onehot;
    logic [2:0]    w_enc;
    logic [2:0]    w_ptr_nxt;
    logic [AW-1:0] w_dst;
    int            w_p;

    // A source granted last cycle is masked out so it cannot win twice in a row.
    assign w_eff   = bus.req & ~r_gnt;
    assign w_start = RR_EN ? r_ptr : 3'd0;

    // Scan upward from the start index, wrapping 5 -> 0; first set bit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        w_p     = 0;
        for (int k = 0; k < 6; k++) begin
            w_p = int'(w_start) + k;
            if (w_p > 5) w_p = w_p - 6;
            if (!w_found && w_eff[w_p]) begin
                w_found = 1'b1;
                w_idx   = 3'(w_p);
            end
        end
    end

    // Winner index to mux select; codes 011 and 111 are skipped.
    always_comb begin
        w_enc = 3'b000;
        unique case (w_idx)
            3'd0:    w_enc = 3'b000;
            3'd1:    w_enc = 3'b001;
            3'd2:    w_enc = 3'b010;
            3'd3:    w_enc = 3'b100;
            3'd4:    w_enc = 3'b101;
            3'd5:    w_enc = 3'b110;
            default: w_enc = 3'b000;
        endcase
    end

    assign w_onehot  = 6'b000001 << w_idx;
    assign w_ptr_nxt = (w_idx == 3'd5) ? 3'd0 : w_idx + 3'd1;
    assign w_dst     = bus.dst[w_idx*AW +: AW];

    // Grant, write port and pointer update; hold freezes select/address/pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= 6'd0;
            r_sel   <= 3'b000;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= 3'd0;
        end else if (bus.hold) begin
            r_gnt  <= 6'd0;
            r_we   <= 1'b0;
            r_busy <= |bus.req;
        end else if (w_found) begin
            r_gnt   <= w_onehot;
            r_sel   <= w_enc;
            r_we    <= 1'b1;
            r_waddr <= w_dst;
            r_busy  <= |(w_eff & ~w_onehot);
            if (RR_EN) r_ptr <= w_ptr_nxt;
        end else begin
            r_gnt  <= 6'd0;
            r_we   <= 1'b0;
            r_busy <= 1'b0;
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.sel   = r_sel;
    assign bus.we    = r_we;
    assign bus.waddr = r_waddr;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter.
// Covers a round-robin instance and a fixed-priority instance.
module tb_wb_port_arbiter;

    logic clk;
    logic rst;

    wb_port_arbiter_if #(.AW(4)) ra ();
    wb_port_arbiter_if #(.AW(4)) fa ();

    wb_port_arbiter #(.AW(4), .RR_EN(1'b1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (ra)
    );

    wb_port_arbiter #(.AW(4), .RR_EN(1'b0)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (fa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         fp;
        logic [5:0] gnt;
        logic [2:0] sel;
        logic       we;
        logic [3:0] waddr;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Push expectation, advance one edge, pop and compare.
    task automatic step(input string tag, input bit fp,
                        input logic [5:0] g, input logic [2:0] s,
                        input logic w, input logic [3:0] a,
                        input logic b);
        exp_t e;
        e.tag = tag; e.fp = fp; e.gnt = g; e.sel = s;
        e.we = w; e.waddr = a; e.busy = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            if (e.fp) begin
                chk({e.tag, ".gnt"},   8'(fa.gnt),   8'(e.gnt));
                chk({e.tag, ".sel"},   8'(fa.sel),   8'(e.sel));
                chk({e.tag, ".we"},    8'(fa.we),    8'(e.we));
                chk({e.tag, ".waddr"}, 8'(fa.waddr), 8'(e.waddr));
                chk({e.tag, ".busy"},  8'(fa.busy),  8'(e.busy));
            end else begin
                chk({e.tag, ".gnt"},   8'(ra.gnt),   8'(e.gnt));
                chk({e.tag, ".sel"},   8'(ra.sel),   8'(e.sel));
                chk({e.tag, ".we"},    8'(ra.we),    8'(e.we));
                chk({e.tag, ".waddr"}, 8'(ra.waddr), 8'(e.waddr));
                chk({e.tag, ".busy"},  8'(ra.busy),  8'(e.busy));
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        ra.req  = 6'h3F;
        ra.hold = 1'b0;
        fa.req  = 6'h00;
        fa.hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ra.dst[i*4 +: 4] = 4'(i + 1);
            fa.dst[i*4 +: 4] = 4'(15 - i);
        end

        // Reset held with all requests pending
        step("rst0", 0, 6'h00, 3'b000, 0, 4'd0, 0);
        step("rst1", 0, 6'h00, 3'b000, 0, 4'd0, 0);
        step("rst2", 0, 6'h00, 3'b000, 0, 4'd0, 0);
        rst = 1'b0;
        step("rst_first", 0, 6'h01, 3'b000, 1, 4'd1, 1);
        ra.req = 6'h00;
        step("rst_idle", 0, 6'h00, 3'b000, 0, 4'd1, 0);

        // Single request from source 2 (ptr is 1 here)
        ra.req = 6'b000100;
        ra.dst[2*4 +: 4] = 4'd5;
        step("single", 0, 6'h04, 3'b010, 1, 4'd5, 0);
        ra.req = 6'h00;
        ra.dst[2*4 +: 4] = 4'd9;
        step("single_after", 0, 6'h00, 3'b010, 0, 4'd5, 0);

        // Round-robin sweep from a fresh pointer
        for (int i = 0; i < 6; i++) ra.dst[i*4 +: 4] = 4'(i + 8);
        rst = 1'b1;
        step("sweep_rst", 0, 6'h00, 3'b000, 0, 4'd0, 0);
        rst = 1'b0;
        ra.req = 6'h3F;
        step("sweep0", 0, 6'h01, 3'b000, 1, 4'd8,  1);
        step("sweep1", 0, 6'h02, 3'b001, 1, 4'd9,  1);
        step("sweep2", 0, 6'h04, 3'b010, 1, 4'd10, 1);
        step("sweep3", 0, 6'h08, 3'b100, 1, 4'd11, 1);
        step("sweep4", 0, 6'h10, 3'b101, 1, 4'd12, 1);
        step("sweep5", 0, 6'h20, 3'b110, 1, 4'd13, 1);
        step("sweep6", 0, 6'h01, 3'b000, 1, 4'd8,  1);
        ra.req = 6'h00;
        step("sweep_idle", 0, 6'h00, 3'b000, 0, 4'd8, 0);

        // Stall with sources 0 and 3 pending
        rst = 1'b1;
        step("stall_rst", 0, 6'h00, 3'b000, 0, 4'd0, 0);
        rst = 1'b0;
        ra.req  = 6'b001001;
        ra.hold = 1'b1;
        step("stall0", 0, 6'h00, 3'b000, 0, 4'd0, 1);
        step("stall1", 0, 6'h00, 3'b000, 0, 4'd0, 1);
        step("stall2", 0, 6'h00, 3'b000, 0, 4'd0, 1);
        step("stall3", 0, 6'h00, 3'b000, 0, 4'd0, 1);
        ra.hold = 1'b0;
        step("stall_rel0", 0, 6'h01, 3'b000, 1, 4'd8,  1);
        step("stall_rel3", 0, 6'h08, 3'b100, 1, 4'd11, 0);
        ra.req = 6'h00;
        step("stall_idle", 0, 6'h00, 3'b100, 0, 4'd11, 0);

        // Reset in the middle of a grant to source 4 (ptr is 4)
        ra.req = 6'b010000;
        step("mid_g4", 0, 6'h10, 3'b101, 1, 4'd12, 0);
        rst = 1'b1;
        ra.req = 6'h30;
        step("mid_rst", 0, 6'h00, 3'b000, 0, 4'd0, 0);
        rst = 1'b0;
        step("mid_g4b", 0, 6'h10, 3'b101, 1, 4'd12, 1);
        step("mid_g5",  0, 6'h20, 3'b110, 1, 4'd13, 0);
        ra.req = 6'h00;
        step("mid_idle", 0, 6'h00, 3'b110, 0, 4'd13, 0);

        // Fixed priority: sources 1 and 5 alternate due to masking
        fa.req = 6'b100010;
        step("fp0", 1, 6'h02, 3'b001, 1, 4'd14, 1);
        step("fp1", 1, 6'h20, 3'b110, 1, 4'd10, 0);
        step("fp2", 1, 6'h02, 3'b001, 1, 4'd14, 0);
        step("fp3", 1, 6'h20, 3'b110, 1, 4'd10, 0);
        step("fp4", 1, 6'h02, 3'b001, 1, 4'd14, 0);
        step("fp5", 1, 6'h20, 3'b110, 1, 4'd10, 0);
        fa.req = 6'h00;
        step("fp_idle", 1, 6'h00, 3'b110, 0, 4'd10, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
